uart_time_cmd_decoder: RTL
==========================

// Module: uart_time_cmd_decoder
// PURPOSE
//  Decodes a UART byte stream into time-set commands for the clock and NUM_ALARMS alarm channels.
//  Frame: command byte, hour, minute[, second]. Commands select a channel, fields are range-checked,
//  and a valid frame commits to a one-hot load pulse. Supersedes the fixed clock/alarm decoder; sits
//  between the UART receiver and the time-keeping/alarm registers.
// PARAMETERS
//  NUM_ALARMS    2        alarm channels; channel 0 = clock, 1..NUM_ALARMS = alarms
//  TIMEOUT_CYC   100000   max idle cycles between frame bytes before abort to ERROR
//  ERR_CYC       153600   cycles led_err held in ERROR before return to IDLE
//  OK_CYC        76800    cycles led_ok held after a successful commit
// PORTS
//  clk        in   1             clock
//  reset_     in   1             asynchronous, active-low reset
//  rx_byte    in   8             received byte, valid when rx_valid=1
//  rx_valid   in   1             one-cycle strobe per received byte
//  hour_o     out  5             committed hour (0..23)
//  min_o      out  6             committed minute (0..59)
//  sec_o      out  6             committed second (0..59); present only with CMD_SECONDS_EN
//  load_o     out  NUM_ALARMS+1  one-hot, one-cycle load strobe; bit k = channel k
//  led_ok     out  1             success indicator
//  led_err    out  1             error indicator
//  busy       out  1             1 in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; hour_o/min_o/sec_o=0; load_o=0; led_ok=0; led_err=0; busy=0; all timers 0.
//  Command code: rx_byte = 8'h01+k selects channel k, k in 0..NUM_ALARMS; any other value -> ERROR.
//  IDLE: on rx_valid, decode command -> GET_HOUR (latch channel) or ERROR; a command byte clears led_ok.
//  GET_HOUR: on rx_valid, rx_byte<=23 (full 8-bit compare) -> latch, GET_MIN; else ERROR.
//  GET_MIN: on rx_valid, rx_byte<=59 -> latch, GET_SEC (macro) or COMMIT; else ERROR.
//  GET_SEC: on rx_valid, rx_byte<=59 -> latch, COMMIT; else ERROR.
//  GET_* timeout: counter reloads on each accepted byte; TIMEOUT_CYC cycles without rx_valid -> ERROR.
//  COMMIT (1 cycle): drive latched fields onto hour_o/min_o/sec_o, load_o[ch]=1 for this cycle only,
//   led_ok=1, led_err=0, start OK timer, -> IDLE. Last field byte at edge N -> load_o high N..N+1.
//   hour_o/min_o/sec_o hold their value until the next COMMIT; a failed frame never changes them.
//  ERROR: led_err=1, led_ok=0, partial frame discarded, ERR_CYC count -> IDLE, led_err=0 on exit.
//  OK timer: led_ok drops to 0 after OK_CYC cycles in any state, or on a new command byte.
//  Dropped bytes: rx_valid in COMMIT or ERROR is discarded silently; ERROR timer is not restarted.
//  Timer widths: $clog2(max+1); counters saturate at their terminal count, never wrap.
//  Reset mid-frame: async return to the reset state; partially latched fields are lost.
// CONFIGURATION
//  CMD_SECONDS_EN defined: GET_SEC state, sec_o port, 4-byte frame.
//  CMD_SECONDS_EN undefined: 3-byte frame; GET_MIN goes to COMMIT; sec_o and GET_SEC absent.
// STRUCTURE
//  Package uart_clk_pkg: state enum (IDLE, GET_HOUR, GET_MIN, GET_SEC, COMMIT, ERROR),
//   CMD_BASE=8'h01, MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59.
//  Sub-module cmd_timer (load/enable/done down-counter, width parameter), instanced three times:
//   byte timeout, error hold, OK hold.
// TESTING
//  1. 01,0C,1E -> load_o=001 for 1 cycle, hour_o=12, min_o=30, led_ok=1; led_ok=0 after OK_CYC.
//  2. 03,07,00 (NUM_ALARMS=2) -> load_o=100, hour_o=7, min_o=0.
//  3. 04 -> ERROR, led_err=1 for ERR_CYC cycles, no load; then 01,00,00 accepted.
//  4. 01,18 (hour=24) -> ERROR, hour_o/min_o unchanged; 01,0A,3C (min=60) -> ERROR.
//  5. 02,05 then silence for TIMEOUT_CYC -> ERROR; bytes sent in ERROR produce no load.
//  6. reset_ low mid-frame after 01,0C -> all outputs 0; with CMD_SECONDS_EN: 01,17,3B,3B -> sec_o=59.

Source files
------------

// File: rtl/uart_clk_pkg.sv
// Shared types and constants for the UART time-command decoder.
//   state_e  : decoder FSM states
//   CMD_BASE : command byte for channel 0 (clock); CMD_BASE+k selects channel k
//   MAX_*    : inclusive upper bounds for the hour/minute/second field bytes
package uart_clk_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_HOUR = 3'd1,
        GET_MIN  = 3'd2,
        GET_SEC  = 3'd3,
        COMMIT   = 3'd4,
        ERROR    = 3'd5
    } state_e;

    localparam logic [7:0] CMD_BASE = 8'h01;
    localparam logic [7:0] MAX_HOUR = 8'd23;
    localparam logic [7:0] MAX_MIN  = 8'd59;
    localparam logic [7:0] MAX_SEC  = 8'd59;

endpackage

// File: rtl/uart_time_cmd_decoder_cmd_timer.sv
// cmd_timer: loadable down-counter that saturates at zero.
//   clk, reset_  : clock, asynchronous active-low reset (count clears to 0)
//   load_i       : reload counter with load_val_i (has priority over en_i)
//   load_val_i   : reload value
//   en_i         : decrement by one per cycle while non-zero
//   done_o       : registered, high while the count is zero
module cmd_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload, decrement, or hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q  <= '0;
            done_o <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            done_o <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/uart_time_cmd_decoder.sv
// uart_time_cmd_decoder: turns a UART byte stream into time-set commands.
// Frame: command byte (CMD_BASE+k selects channel k), hour, minute[, second].
// A fully valid frame drives hour_o/min_o[/sec_o] and a one-cycle one-hot load_o.
// Optional feature macro: CMD_SECONDS_EN adds the seconds byte and the sec_o port.
// Ports:
//   clk, reset_  : clock, asynchronous active-low reset
//   rx_byte      : received byte, qualified by rx_valid (one-cycle strobe)
//   hour_o       : committed hour (0..23)
//   min_o        : committed minute (0..59)
//   sec_o        : committed second (0..59), only with CMD_SECONDS_EN
//   load_o       : one-hot load strobe, bit k = channel k (0 = clock)
//   led_ok       : high for OK_CYC cycles after a commit
//   led_err      : high for ERR_CYC cycles after a rejected/timed-out frame
//   busy         : high whenever the decoder is not idle
module uart_time_cmd_decoder
    import uart_clk_pkg::*;
#(
    parameter int unsigned NUM_ALARMS  = 2,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned ERR_CYC     = 153600,
    parameter int unsigned OK_CYC      = 76800
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [4:0]            hour_o,
    output logic [5:0]            min_o,
`ifdef CMD_SECONDS_EN
    output logic [5:0]            sec_o,
`endif
    output logic [NUM_ALARMS:0]   load_o,
    output logic                  led_ok,
    output logic                  led_err,
    output logic                  busy
);

    localparam int unsigned LD_W  = NUM_ALARMS + 1;
    localparam int unsigned CH_W  = (NUM_ALARMS > 0) ? $clog2(NUM_ALARMS + 1) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned ERR_W = $clog2(ERR_CYC + 1);
    localparam int unsigned OK_W  = $clog2(OK_CYC + 1);

    state_e            state_q;
    logic [CH_W-1:0]   ch_q;
    logic [4:0]        hour_lat_q;
`ifdef CMD_SECONDS_EN
    logic [5:0]        min_lat_q;
`endif

    logic [7:0]        cmd_off_c;
    logic              cmd_ok_c;
    logic              in_get_c;
    logic              to_done;
    logic              err_done;
    logic              ok_done;

    // Command decode: offset from CMD_BASE must land on an existing channel.
    assign cmd_off_c = rx_byte - CMD_BASE;
    assign cmd_ok_c  = (rx_byte >= CMD_BASE) && (cmd_off_c <= 8'(NUM_ALARMS));
    assign in_get_c  = (state_q == GET_HOUR) || (state_q == GET_MIN) || (state_q == GET_SEC);

    // Byte timeout: held at reload outside field states and on every byte, so it
    // counts only idle cycles within a frame; expires after TIMEOUT_CYC of them.
    cmd_timer #(.W(TO_W)) u_to_tmr (
        .clk        (clk),
        .reset_     (reset_),
        .load_i     (!in_get_c || rx_valid),
        .load_val_i (TO_W'(TIMEOUT_CYC - 1)),
        .en_i       (in_get_c),
        .done_o     (to_done)
    );

    // Error hold: armed while outside ERROR, so it runs exactly once per error
    // and incoming bytes cannot restart it.
    cmd_timer #(.W(ERR_W)) u_err_tmr (
        .clk        (clk),
        .reset_     (reset_),
        .load_i     (state_q != ERROR),
        .load_val_i (ERR_W'(ERR_CYC - 1)),
        .en_i       (state_q == ERROR),
        .done_o     (err_done)
    );

    // OK hold: armed while led_ok is low, runs from the commit edge onward.
    cmd_timer #(.W(OK_W)) u_ok_tmr (
        .clk        (clk),
        .reset_     (reset_),
        .load_i     (!led_ok),
        .load_val_i (OK_W'(OK_CYC - 1)),
        .en_i       (led_ok),
        .done_o     (ok_done)
    );

    // Frame FSM; the commit edge is the one that accepts the last field byte,
    // so load_o and the time outputs are valid during the COMMIT cycle.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            hour_lat_q <= '0;
`ifdef CMD_SECONDS_EN
            min_lat_q  <= '0;
            sec_o      <= '0;
`endif
            hour_o     <= '0;
            min_o      <= '0;
            load_o     <= '0;
            led_ok     <= 1'b0;
            led_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            load_o <= '0;
            if (led_ok && ok_done) begin
                led_ok <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        led_ok <= 1'b0;
                        busy   <= 1'b1;
                        if (cmd_ok_c) begin
                            ch_q    <= CH_W'(cmd_off_c);
                            state_q <= GET_HOUR;
                        end else begin
                            state_q <= ERROR;
                            led_err <= 1'b1;
                        end
                    end
                end
                GET_HOUR: begin
                    if (rx_valid) begin
                        if (rx_byte <= MAX_HOUR) begin
                            hour_lat_q <= 5'(rx_byte);
                            state_q    <= GET_MIN;
                        end else begin
                            state_q <= ERROR;
                            led_err <= 1'b1;
                            led_ok  <= 1'b0;
                        end
                    end else if (to_done) begin
                        state_q <= ERROR;
                        led_err <= 1'b1;
                        led_ok  <= 1'b0;
                    end
                end
                GET_MIN: begin
                    if (rx_valid) begin
                        if (rx_byte <= MAX_MIN) begin
`ifdef CMD_SECONDS_EN
                            min_lat_q <= 6'(rx_byte);
                            state_q   <= GET_SEC;
`else
                            hour_o  <= hour_lat_q;
                            min_o   <= 6'(rx_byte);
                            load_o  <= LD_W'(1) << ch_q;
                            led_ok  <= 1'b1;
                            led_err <= 1'b0;
                            state_q <= COMMIT;
`endif
                        end else begin
                            state_q <= ERROR;
                            led_err <= 1'b1;
                            led_ok  <= 1'b0;
                        end
                    end else if (to_done) begin
                        state_q <= ERROR;
                        led_err <= 1'b1;
                        led_ok  <= 1'b0;
                    end
                end
`ifdef CMD_SECONDS_EN
                GET_SEC: begin
                    if (rx_valid) begin
                        if (rx_byte <= MAX_SEC) begin
                            hour_o  <= hour_lat_q;
                            min_o   <= min_lat_q;
                            sec_o   <= 6'(rx_byte);
                            load_o  <= LD_W'(1) << ch_q;
                            led_ok  <= 1'b1;
                            led_err <= 1'b0;
                            state_q <= COMMIT;
                        end else begin
                            state_q <= ERROR;
                            led_err <= 1'b1;
                            led_ok  <= 1'b0;
                        end
                    end else if (to_done) begin
                        state_q <= ERROR;
                        led_err <= 1'b1;
                        led_ok  <= 1'b0;
                    end
                end
`endif
                COMMIT: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                ERROR: begin
                    led_ok <= 1'b0;
                    if (err_done) begin
                        state_q <= IDLE;
                        led_err <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
